// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// ssd_pkg : shared constants, glyph table and frame record for the SSD scanner
// Revision: 1.0
// ============================================================================
package ssd_pkg;

  localparam int         SSD_DIGITS = 4;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;

  // Glyphs are {a,b,c,d,e,f,g}, active-low; dp is appended by the decoder.
  localparam logic [6:0] SEG_0 = 7'b000_0001;
  localparam logic [6:0] SEG_1 = 7'b100_1111;
  localparam logic [6:0] SEG_2 = 7'b001_0010;
  localparam logic [6:0] SEG_3 = 7'b000_0110;
  localparam logic [6:0] SEG_4 = 7'b100_1100;
  localparam logic [6:0] SEG_5 = 7'b010_0100;
  localparam logic [6:0] SEG_6 = 7'b010_0000;
  localparam logic [6:0] SEG_7 = 7'b000_1111;
  localparam logic [6:0] SEG_8 = 7'b000_0000;
  localparam logic [6:0] SEG_9 = 7'b000_0100;
  localparam logic [6:0] SEG_A = 7'b000_1000;
  localparam logic [6:0] SEG_B = 7'b110_0000;
  localparam logic [6:0] SEG_C = 7'b011_0001;
  localparam logic [6:0] SEG_D = 7'b100_0010;
  localparam logic [6:0] SEG_E = 7'b011_0000;
  localparam logic [6:0] SEG_F = 7'b011_1000;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  blink;
    logic [3:0]  dp;
  } ssd_frame_t;

  localparam ssd_frame_t FRAME_RESET = '{digits: 16'h0000, blank: 4'hF, blink: 4'h0, dp: 4'h0};

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = SEG_0;   4'h1: g = SEG_1;   4'h2: g = SEG_2;   4'h3: g = SEG_3;
      4'h4: g = SEG_4;   4'h5: g = SEG_5;   4'h6: g = SEG_6;   4'h7: g = SEG_7;
      4'h8: g = SEG_8;   4'h9: g = SEG_9;   4'hA: g = SEG_A;   4'hB: g = SEG_B;
      4'hC: g = SEG_C;   4'hD: g = SEG_D;   4'hE: g = SEG_E;   default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// ssd_scan_ctrl_if : write handshake from the datapath plus the SSD pin bundle
// Revision: 1.0
// ============================================================================
interface ssd_scan_ctrl_if;
  logic        wr_en;
  logic [15:0] wr_digits;
  logic [3:0]  wr_blank;
  logic [3:0]  wr_blink;
  logic [3:0]  wr_dp;
  logic        wr_ready;
  logic        frame_done;
  logic [3:0]  ssd_ctl;
  logic [7:0]  ssd_seg;

  modport master (
    output wr_en, wr_digits, wr_blank, wr_blink, wr_dp,
    input  wr_ready, frame_done, ssd_ctl, ssd_seg
  );

  modport slave (
    input  wr_en, wr_digits, wr_blank, wr_blink, wr_dp,
    output wr_ready, frame_done, ssd_ctl, ssd_seg
  );
endinterface
`default_nettype wire

// File: rtl/ssd_seg_decode.sv
`default_nettype none
// ============================================================================
// ssd_seg_decode : hex nibble + decimal point + dark flag -> active-low segments
// Revision: 1.0
// ============================================================================
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  wire logic [3:0] nibble_i,
  input  wire logic       dp_i,
  input  wire logic       dark_i,
  output logic      [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!dark_i) begin
      seg_o = {hex_glyph(nibble_i), ~dp_i};
    end
  end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// ssd_scan_ctrl : 4-digit SSD scanner with frame-aligned double buffering,
//                 per-digit blank/blink and decimal points
// Revision: 1.0
// ============================================================================
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV_BIT = 17,
  parameter int BLINK_FRAMES = 64
) (
  input  wire logic   clk,
  input  wire logic   rst,
  ssd_scan_ctrl_if.slave bus
);

  localparam logic [SCAN_DIV_BIT-1:0] PRE_ONE    = 1;
  localparam logic [7:0]              BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [SCAN_DIV_BIT-1:0] pre_cnt_q;
  logic [1:0]              idx_q;
  logic                    pend_q;
  ssd_frame_t              staging_q;
  ssd_frame_t              active_q;
  logic [7:0]              blink_cnt_q;
  logic                    blink_phase_q;
  logic                    frame_done_q;
  logic [3:0]              ssd_ctl_q;
  logic [7:0]              ssd_seg_q;

  logic       scan_tick_w;
  logic       fb_w;
  logic       accept_w;
  logic [3:0] nibble_w;
  logic       dark_w;
  logic [7:0] seg_d;

  assign scan_tick_w = &pre_cnt_q;
  assign fb_w        = scan_tick_w && (idx_q == 2'd3);
  assign accept_w    = bus.wr_en && !pend_q;
  assign nibble_w    = active_q.digits[{idx_q, 2'b00} +: 4];
  assign dark_w      = active_q.blank[idx_q] | (active_q.blink[idx_q] & blink_phase_q);

  ssd_seg_decode u_decode (
    .nibble_i (nibble_w),
    .dp_i     (active_q.dp[idx_q]),
    .dark_i   (dark_w),
    .seg_o    (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q     <= '0;
      idx_q         <= 2'd0;
      pend_q        <= 1'b0;
      staging_q     <= '0;
      active_q      <= FRAME_RESET;
      blink_cnt_q   <= 8'd0;
      blink_phase_q <= 1'b0;
      frame_done_q  <= 1'b0;
      ssd_ctl_q     <= 4'b1111;
      ssd_seg_q     <= SEG_BLANK;
    end else begin
      pre_cnt_q    <= pre_cnt_q + PRE_ONE;
      frame_done_q <= fb_w;
      ssd_ctl_q    <= ~(4'b0001 << idx_q);
      ssd_seg_q    <= seg_d;
      if (scan_tick_w) begin
        idx_q <= idx_q + 2'd1;
      end
      if (fb_w) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_q   <= 8'd0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 8'd1;
        end
      end
      // Commit and accept are exclusive on pend, so a write landing on fb waits a frame.
      if (fb_w && pend_q) begin
        active_q <= staging_q;
        pend_q   <= 1'b0;
      end
      if (accept_w) begin
        staging_q <= '{digits: bus.wr_digits, blank: bus.wr_blank,
                       blink: bus.wr_blink, dp: bus.wr_dp};
        pend_q    <= 1'b1;
      end
    end
  end

  assign bus.wr_ready   = ~pend_q;
  assign bus.frame_done = frame_done_q;
  assign bus.ssd_ctl    = ssd_ctl_q;
  assign bus.ssd_seg    = ssd_seg_q;

endmodule
`default_nettype wire
